ko_detector: RTL and testbench
==============================

// Module: ko_detector
// PURPOSE
//  Per-player blast-zone knockout detector; directly upstream of the lives/game-state FSM.
//  Watches both fighters' positions once per frame and emits the one-cycle death_1/death_2
//  pulses that FSM decrements lives on. Sequences each KO'd fighter through a respawn hold
//  (and optional invulnerability window) so a single KO never produces a second pulse.
// PARAMETERS
//  BZ_LEFT        16   x below this = out of bounds
//  BZ_RIGHT       623  x above this = out of bounds
//  BZ_BOTTOM      479  y above this = out of bounds (y grows downward)
//  OUT_FRAMES     2    consecutive out-of-bounds frame ticks required before KO (1..15)
//  RESPAWN_FRAMES 90   frame ticks spent in RESPAWN (1..255)
//  INVULN_FRAMES  120  frame ticks spent in INVULN (1..255; used only with KO_INVULN_EN)
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous, active-high reset
//  frame_tick   in   1   one-clk pulse per video frame; all frame counting keys off it
//  game_active  in   1   high while the game-state FSM is in play
//  c1x, c1y     in   10  fighter 1 position, unsigned
//  c2x, c2y     in   10  fighter 2 position, unsigned
//  death_1      out  1   one-clk KO pulse, fighter 1
//  death_2      out  1   one-clk KO pulse, fighter 2
//  respawn_1    out  1   high while fighter 1 is held at spawn
//  respawn_2    out  1   high while fighter 2 is held at spawn
//  invuln_1     out  1   high during fighter 1 INVULN (tied 0 without KO_INVULN_EN)
//  invuln_2     out  1   high during fighter 2 INVULN (tied 0 without KO_INVULN_EN)
// BEHAVIOUR
//  - Two identical, independent per-player FSMs: ALIVE -> KO -> RESPAWN -> [INVULN] -> ALIVE.
//  - Reset: all FSMs ALIVE; all counters 0; every output 0.
//  - out_of_bounds = (x < BZ_LEFT) | (x > BZ_RIGHT) | (y > BZ_BOTTOM).
//    - Underflowed positions (e.g. 10'h3F0) are therefore out: a value > BZ_RIGHT or > BZ_BOTTOM.
//  - ALIVE, on frame_tick:
//    - Out of bounds: out_cnt += 1. In bounds: out_cnt = 0.
//    - Move to KO on the tick where out_cnt would reach OUT_FRAMES.
//    - out_cnt saturates; it never wraps.
//  - KO lasts exactly one clk.
//    - death_N is registered high for that clk only; next state is RESPAWN.
//    - Total latency: death_N rises 1 clk after the qualifying frame_tick.
//  - RESPAWN: respawn_N = 1; positions are ignored.
//    - Counts RESPAWN_FRAMES frame ticks, then goes to INVULN (macro on) or ALIVE (macro off).
//    - Frame counter and out_cnt are cleared on exit.
//  - INVULN: invuln_N = 1; positions are ignored; counts INVULN_FRAMES ticks, then ALIVE.
//  - Simultaneous KOs: death_1 and death_2 may assert in the same clk; they must not be serialised.
//  - game_active low: FSMs forced to ALIVE and counters cleared on the next clk.
//    - No death pulse may issue while game_active is low.
//    - A KO state entered in the same clk that game_active falls still completes its one pulse.
//  - frame_tick high during a KO clk is ignored; RESPAWN counting starts at the next tick.
//  - reset asserted mid-sequence returns the FSM to ALIVE immediately (async), outputs 0.
// CONFIGURATION
//  - KO_INVULN_EN defined: INVULN state, its counter and the invuln_N outputs are built.
//  - KO_INVULN_EN undefined: RESPAWN exits directly to ALIVE; invuln_1/invuln_2 = 0;
//    INVULN_FRAMES is unused.
// TESTING
//  - Reset, game_active=1, c1=(300,200) for 10 ticks -> death_1=0, respawn_1=0 throughout.
//  - c1y=480 for 2 ticks (OUT_FRAMES=2) -> death_1=1 for exactly 1 clk, 1 clk after 2nd tick;
//    then respawn_1=1 for 90 ticks.
//  - c1x=700 one tick, then c1x=300, repeated alternately -> out_cnt never reaches 2; no death_1.
//  - c1y=480 and c2x=10 on the same ticks -> death_1 and death_2 high in the same single clk.
//  - Fighter out of bounds throughout RESPAWN -> no second death pulse;
//    - macro on: invuln_1=1 for 120 ticks, then ALIVE; a KO re-arms only after re-qualifying.
//  - Reset pulse mid-RESPAWN, or game_active=0 -> respawn_1=0 next clk;
//    c1x=1008 afterwards with game_active=0 -> no death_1.

Source files
------------

// File: rtl/ko_detector.sv
// Blast-zone KO detector: one independent ALIVE/KO/RESPAWN[/INVULN] FSM per fighter.
// Build option: define KO_INVULN_EN to add the post-respawn INVULN state and invuln_N outputs.

module ko_player #(
    parameter int BZ_LEFT        = 16,
    parameter int BZ_RIGHT       = 623,
    parameter int BZ_BOTTOM      = 479,
    parameter int OUT_FRAMES     = 2,
    parameter int RESPAWN_FRAMES = 90,
    parameter int INVULN_FRAMES  = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       game_active,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic       death,
    output logic       respawn,
    output logic       invuln
);
    localparam logic [1:0] S_ALIVE   = 2'd0;
    localparam logic [1:0] S_KO      = 2'd1;
    localparam logic [1:0] S_RESPAWN = 2'd2;
    localparam logic [1:0] S_INVULN  = 2'd3;

    // One frame counter serves both hold states, so size it for the longer one.
    localparam int FMAX = (RESPAWN_FRAMES > INVULN_FRAMES) ? RESPAWN_FRAMES : INVULN_FRAMES;
    localparam int FCW  = $clog2(FMAX + 1);

    localparam logic [9:0]     BZ_L     = 10'(BZ_LEFT);
    localparam logic [9:0]     BZ_R     = 10'(BZ_RIGHT);
    localparam logic [9:0]     BZ_B     = 10'(BZ_BOTTOM);
    localparam logic [3:0]     OUT_LAST = 4'(OUT_FRAMES - 1);
    localparam logic [FCW-1:0] RSP_LAST = FCW'(RESPAWN_FRAMES - 1);
`ifdef KO_INVULN_EN
    localparam logic [FCW-1:0] INV_LAST = FCW'(INVULN_FRAMES - 1);
`endif

    logic [1:0]     state, state_n;
    logic [3:0]     out_cnt, out_cnt_n;
    logic [FCW-1:0] frame_cnt, frame_cnt_n;
    logic           oob;

    // Underflowed (wrapped) coordinates land above BZ_RIGHT/BZ_BOTTOM and count as out.
    assign oob = (x < BZ_L) | (x > BZ_R) | (y > BZ_B);

    always_comb begin
        state_n     = state;
        out_cnt_n   = out_cnt;
        frame_cnt_n = frame_cnt;
        if (!game_active) begin
            state_n     = S_ALIVE;
            out_cnt_n   = '0;
            frame_cnt_n = '0;
        end else begin
            case (state)
                S_ALIVE: begin
                    if (frame_tick) begin
                        if (!oob) begin
                            out_cnt_n = '0;
                        end else begin
                            out_cnt_n = (out_cnt == 4'hF) ? out_cnt : out_cnt + 4'd1;
                            if (out_cnt >= OUT_LAST) state_n = S_KO;
                        end
                    end
                end
                // Single-clk state; a frame_tick landing here is deliberately dropped.
                S_KO: begin
                    state_n     = S_RESPAWN;
                    frame_cnt_n = '0;
                end
                S_RESPAWN: begin
                    if (frame_tick) begin
                        if (frame_cnt == RSP_LAST) begin
                            frame_cnt_n = '0;
                            out_cnt_n   = '0;
`ifdef KO_INVULN_EN
                            state_n     = S_INVULN;
`else
                            state_n     = S_ALIVE;
`endif
                        end else begin
                            frame_cnt_n = frame_cnt + 1'b1;
                        end
                    end
                end
`ifdef KO_INVULN_EN
                S_INVULN: begin
                    if (frame_tick) begin
                        if (frame_cnt == INV_LAST) begin
                            frame_cnt_n = '0;
                            out_cnt_n   = '0;
                            state_n     = S_ALIVE;
                        end else begin
                            frame_cnt_n = frame_cnt + 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state_n     = S_ALIVE;
                    out_cnt_n   = '0;
                    frame_cnt_n = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_ALIVE;
            out_cnt   <= '0;
            frame_cnt <= '0;
            death     <= 1'b0;
            respawn   <= 1'b0;
        end else begin
            state     <= state_n;
            out_cnt   <= out_cnt_n;
            frame_cnt <= frame_cnt_n;
            death     <= (state_n == S_KO);
            respawn   <= (state_n == S_RESPAWN);
        end
    end

`ifdef KO_INVULN_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) invuln <= 1'b0;
        else       invuln <= (state_n == S_INVULN);
    end
`else
    assign invuln = 1'b0;
`endif

endmodule

module ko_detector #(
    parameter int BZ_LEFT        = 16,
    parameter int BZ_RIGHT       = 623,
    parameter int BZ_BOTTOM      = 479,
    parameter int OUT_FRAMES     = 2,
    parameter int RESPAWN_FRAMES = 90,
    parameter int INVULN_FRAMES  = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       game_active,
    input  logic [9:0] c1x,
    input  logic [9:0] c1y,
    input  logic [9:0] c2x,
    input  logic [9:0] c2y,
    output logic       death_1,
    output logic       death_2,
    output logic       respawn_1,
    output logic       respawn_2,
    output logic       invuln_1,
    output logic       invuln_2
);
    localparam int NUM_PLAYERS = 2;

    logic [NUM_PLAYERS-1:0][9:0] pos_x, pos_y;
    logic [NUM_PLAYERS-1:0]      death_v, respawn_v, invuln_v;

    assign pos_x = {c2x, c1x};
    assign pos_y = {c2y, c1y};

    // Players never interact, so simultaneous KOs pulse together in the same clk.
    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        ko_player #(
            .BZ_LEFT       (BZ_LEFT),
            .BZ_RIGHT      (BZ_RIGHT),
            .BZ_BOTTOM     (BZ_BOTTOM),
            .OUT_FRAMES    (OUT_FRAMES),
            .RESPAWN_FRAMES(RESPAWN_FRAMES),
            .INVULN_FRAMES (INVULN_FRAMES)
        ) u_player (
            .clk        (clk),
            .reset      (reset),
            .frame_tick (frame_tick),
            .game_active(game_active),
            .x          (pos_x[p]),
            .y          (pos_y[p]),
            .death      (death_v[p]),
            .respawn    (respawn_v[p]),
            .invuln     (invuln_v[p])
        );
    end

    assign death_1   = death_v[0];
    assign death_2   = death_v[1];
    assign respawn_1 = respawn_v[0];
    assign respawn_2 = respawn_v[1];
    assign invuln_1  = invuln_v[0];
    assign invuln_2  = invuln_v[1];

endmodule

// File: tb/tb_ko_detector.sv
// Directed bench for ko_detector: blast-zone bounds, KO latency, respawn hold, aborts.
module tb_ko_detector;
    logic       clk = 1'b0;
    logic       reset, frame_tick, game_active;
    logic [9:0] c1x, c1y, c2x, c2y;
    logic       death_1, death_2, respawn_1, respawn_2, invuln_1, invuln_2;

    int checks = 0;
    int failures = 0;
    int d1_cnt = 0, d2_cnt = 0, both_cnt = 0;

    ko_detector dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .game_active(game_active),
        .c1x(c1x), .c1y(c1y), .c2x(c2x), .c2y(c2y),
        .death_1(death_1), .death_2(death_2), .respawn_1(respawn_1), .respawn_2(respawn_2),
        .invuln_1(invuln_1), .invuln_2(invuln_2)
    );

    always #5 clk = ~clk;

    // Pulse counters sample the pre-edge value, so they lag outputs by one clk.
    always @(posedge clk) begin
        if (death_1) d1_cnt <= d1_cnt + 1;
        if (death_2) d2_cnt <= d2_cnt + 1;
        if (death_1 && death_2) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; frame_tick = 1'b0; game_active = 1'b0;
        c1x = 10'd300; c1y = 10'd200; c2x = 10'd300; c2y = 10'd200;
        idle(3);
        chk("rst_death_1", int'(death_1), 0);
        chk("rst_death_2", int'(death_2), 0);
        chk("rst_respawn_1", int'(respawn_1), 0);
        chk("rst_respawn_2", int'(respawn_2), 0);
        chk("rst_invuln_1", int'(invuln_1), 0);
        chk("rst_invuln_2", int'(invuln_2), 0);

        reset = 1'b0; game_active = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("inb_death_1", int'(death_1), 0);
            chk("inb_respawn_1", int'(respawn_1), 0);
        end

        // Exact zone edges are still in bounds.
        c1x = 10'd16;  ticks(3);
        c1x = 10'd623; ticks(3);
        c1x = 10'd300; c1y = 10'd479; c2x = 10'd16; c2y = 10'd479; ticks(3);
        c1y = 10'd200; c2x = 10'd300; c2y = 10'd200;
        idle(2);
        chk("edge_no_death_1", d1_cnt, 0);
        chk("edge_no_death_2", d2_cnt, 0);

        for (int i = 0; i < 5; i++) begin
            c1x = 10'd700; tick();
            c1x = 10'd300; tick();
        end
        idle(2);
        chk("alt_no_death", d1_cnt, 0);

        c1y = 10'd480;
        tick();
        chk("ko_tick1_death", int'(death_1), 0);
        tick();
        chk("ko_death_rise", int'(death_1), 1);
        chk("ko_respawn_pre", int'(respawn_1), 0);
        chk("ko_death_2_quiet", int'(death_2), 0);
        idle(1);
        chk("ko_death_fall", int'(death_1), 0);
        chk("ko_respawn_on", int'(respawn_1), 1);

        ticks(89);
        chk("rsp_hold_89", int'(respawn_1), 1);
        idle(2);
        chk("rsp_no_second_ko", d1_cnt, 1);
        tick();
        chk("rsp_exit", int'(respawn_1), 0);
`ifdef KO_INVULN_EN
        chk("inv_on", int'(invuln_1), 1);
        ticks(119);
        chk("inv_hold_119", int'(invuln_1), 1);
        tick();
        chk("inv_exit", int'(invuln_1), 0);
`else
        chk("inv_tied_off", int'(invuln_1), 0);
`endif
        tick();
        idle(2);
        chk("rearm_needs_requal", d1_cnt, 1);
        chk("rearm_alive", int'(respawn_1), 0);
        c1y = 10'd200; tick();

        c1y = 10'd480; c2x = 10'd10;
        ticks(2);
        chk("sim_death_1", int'(death_1), 1);
        chk("sim_death_2", int'(death_2), 1);
        idle(1);
        chk("sim_fall_1", int'(death_1), 0);
        chk("sim_fall_2", int'(death_2), 0);
        chk("sim_respawn_2", int'(respawn_2), 1);
        idle(2);
        chk("sim_same_clk", both_cnt, 1);
        c1y = 10'd200; c2x = 10'd300;

        ticks(5);
        chk("mid_rsp", int'(respawn_1), 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_respawn_1", int'(respawn_1), 0);
        chk("async_rst_respawn_2", int'(respawn_2), 0);
        @(negedge clk) reset = 1'b0;

        c1y = 10'd480;
        ticks(2);
        chk("ko2_death", int'(death_1), 1);
        c1y = 10'd200;
        ticks(3);
        chk("ko2_respawn", int'(respawn_1), 1);
        game_active = 1'b0;
        idle(1);
        chk("ga_low_respawn", int'(respawn_1), 0);
        c1x = 10'd1008;
        ticks(5);
        idle(2);
        chk("ga_low_no_death", d1_cnt, 3);
        chk("ga_low_death_now", int'(death_1), 0);

        game_active = 1'b1; c1x = 10'd15;
        ticks(2);
        chk("x15_death", int'(death_1), 1);
        game_active = 1'b0; idle(1); game_active = 1'b1;
        c1x = 10'd624;
        tick();
        game_active = 1'b0; idle(1); game_active = 1'b1;
        tick();
        chk("ga_clears_out_cnt", int'(death_1), 0);
        tick();
        chk("x624_death", int'(death_1), 1);
        game_active = 1'b0; idle(3);
        chk("final_d1_cnt", d1_cnt, 5);
        chk("final_d2_cnt", d2_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
